uart_rx: RTL and testbench

//  - Serial-to-parallel UART receiver; consuming end of the 8N1 link driven at the BaudGen bit rate.
//  - Samples the asynchronous rx line, finds the start bit, samples each bit at mid-bit and checks the stop bit.
//  - Presents a received byte with a 1-cycle valid strobe, or flags a framing error.
//  - Sits between the pad-side rx pin and the byte-level consumer (FIFO / command decoder).

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_rx_if.sv | 15 +
 rtl/uart_sync2.sv | 29 ++
 rtl/uart_rx.sv | 132 +++++++++++++
 tb/tb_uart_rx.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants and the receiver state encoding, common to rx, tx and
// baud-generator users.
package uart_pkg;

  localparam int UART_DATA_BITS    = 8;
  localparam int UART_CLKS_PER_BIT = 20;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// Line-side and byte-side signals of the UART receiver; the master drives the
// serial line and consumes bytes, the slave is the receiver itself.
interface uart_rx_if;
  import uart_pkg::*;

  logic                      rx;
  logic [UART_DATA_BITS-1:0] rx_data;
  logic                      rx_valid;
  logic                      frame_err;
  logic                      busy;

  modport master (output rx, input rx_data, rx_valid, frame_err, busy);
  modport slave  (input rx, output rx_data, rx_valid, frame_err, busy);

endinterface

// File: rtl/uart_sync2.sv
// Generic two-flop synchronizer for a single asynchronous bit; both flops
// reset to RST_VAL so the output matches the idle level of the input.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // NOTE: non-blocking assignments let both flops sample their old values on
  // the same edge; blocking here would collapse the chain into one flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizes rx, validates the start bit at mid-bit,
// samples data and stop bits at mid-bit and emits a valid or framing-error strobe.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic     clk,
  input  logic     rst_n,
  uart_rx_if.slave bus
);

  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CNT_W    = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       IDX_LAST  = 3'(UART_DATA_BITS - 1);

  logic rx_s;
  logic rx_q;

  rx_state_e                 state_q,   state_d;
  logic [CNT_W-1:0]          cnt_q,     cnt_d;
  logic [2:0]                bit_idx_q, bit_idx_d;
  logic [UART_DATA_BITS-1:0] shreg_q,   shreg_d;

  logic                      rx_valid_q,  rx_valid_d;
  logic                      frame_err_q, frame_err_d;
  logic [UART_DATA_BITS-1:0] rx_data_q,   rx_data_d;

  uart_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (bus.rx),
    .q_o   (rx_s)
  );

  // Previous synchronized sample; IDLE only reacts to a genuine falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_q <= 1'b1;
    else        rx_q <= rx_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rx_q && !rx_s) state_d = START;
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d              = '0;
          shreg_d[bit_idx_q] = rx_s;
          if (bit_idx_q == IDX_LAST) state_d   = STOP;
          else                       bit_idx_d = bit_idx_q + 1'b1;
        end
      end
      STOP: begin
        // Leave at mid stop bit so a start edge right after it is not missed.
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    rx_data_d   = rx_data_q;
    if (state_q == STOP && cnt_q == BIT_LAST) begin
      if (rx_s) begin
        rx_valid_d = 1'b1;
        rx_data_d  = shreg_q;
      end else begin
        frame_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      rx_data_q   <= '0;
    end else begin
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      rx_data_q   <= rx_data_d;
    end
  end

  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frames are driven on the serial line and the
// expected byte or framing error is queued, then popped when a strobe appears.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CPB = UART_CLKS_PER_BIT;
  localparam int LAT = 2 + 1 + CPB / 2 + 9 * CPB;

  typedef struct {
    logic       is_err;
    logic [7:0] data;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  int         total = 0;
  int         bad   = 0;
  exp_t       exp_q[$];
  int         lat[$];
  logic [7:0] last_good = 8'h00;

  uart_rx_if bus ();

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic send_bit(input logic b);
    bus.rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_ok);
    exp_q.push_back('{is_err: !stop_ok, data: d});
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop_ok);
  endtask

  // Waits up to budget cycles for n strobes, scoring each against the queue.
  task automatic collect(input int n, input int budget);
    int   got;
    exp_t e;
    logic [7:0] want;
    got = 0;
    lat.delete();
    for (int c = 1; c <= budget && got < n; c++) begin
      @(negedge clk);
      if (bus.rx_valid || bus.frame_err) begin
        got++;
        lat.push_back(c);
        total++;
        if (bus.rx_valid && bus.frame_err) begin
          bad++;
          $display("FAIL both_strobes got valid=%b err=%b required one only", bus.rx_valid, bus.frame_err);
        end else if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_strobe got valid=%b err=%b required none", bus.rx_valid, bus.frame_err);
        end else begin
          e = exp_q.pop_front();
          if (bus.frame_err !== e.is_err) begin
            bad++;
            $display("FAIL strobe_kind got frame_err=%b required %b", bus.frame_err, e.is_err);
          end
          want = e.is_err ? last_good : e.data;
          if (!e.is_err) last_good = e.data;
          total++;
          if (bus.rx_data !== want) begin
            bad++;
            $display("FAIL strobe_data got %h required %h", bus.rx_data, want);
          end
        end
      end
    end
    total++;
    if (got != n) begin
      bad++;
      $display("FAIL strobe_count got %0d required %0d", got, n);
    end
  endtask

  task automatic watch_quiet(input string name, input int cycles);
    int hits;
    hits = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (bus.rx_valid || bus.frame_err) hits++;
    end
    total++;
    if (hits != 0) begin
      bad++;
      $display("FAIL %s got %0d strobes required 0", name, hits);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    total++;
    if ({bus.rx_data, bus.rx_valid, bus.frame_err, bus.busy} !== 11'h000) begin
      bad++;
      $display("FAIL %s got data=%h valid=%b err=%b busy=%b required all 0",
               name, bus.rx_data, bus.rx_valid, bus.frame_err, bus.busy);
    end
  endtask

  task automatic test_reset();
    bus.rx = 1'b1;
    #2 rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.rx = ~bus.rx;
      check_idle_outputs("reset_hold");
    end
    bus.rx = 1'b1;
    rst_n  = 1'b1;
    @(negedge clk);
    check_idle_outputs("reset_release");
    watch_quiet("reset_quiet", 300);
  endtask

  task automatic test_single();
    fork
      send_frame(8'hA5, 1'b1);
      collect(1, 260);
    join
    total++;
    if (lat.size() != 1 || lat[0] < LAT - 1 || lat[0] > LAT + 1) begin
      bad++;
      $display("FAIL single_latency got %0d required %0d+/-1", (lat.size() > 0) ? lat[0] : -1, LAT);
    end
    total++;
    if (bus.rx_data !== 8'hA5) begin
      bad++;
      $display("FAIL single_hold got %h required a5", bus.rx_data);
    end
    watch_quiet("single_after", 40);
  endtask

  task automatic test_back_to_back();
    fork
      begin
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
      end
      collect(2, 450);
    join
    total++;
    if (lat.size() != 2 || (lat[1] - lat[0]) != 10 * CPB) begin
      bad++;
      $display("FAIL b2b_spacing got %0d required %0d", (lat.size() == 2) ? lat[1] - lat[0] : -1, 10 * CPB);
    end
    watch_quiet("b2b_after", 40);
  endtask

  task automatic test_glitch();
    int   strobes;
    logic saw_busy;
    strobes  = 0;
    saw_busy = 1'b0;
    bus.rx   = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (c == 4) bus.rx = 1'b1;
      if (bus.busy) saw_busy = 1'b1;
      if (bus.rx_valid || bus.frame_err) strobes++;
    end
    total++;
    if (saw_busy !== 1'b1 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL glitch_busy got seen=%b final=%b required 1 then 0", saw_busy, bus.busy);
    end
    total++;
    if (strobes != 0) begin
      bad++;
      $display("FAIL glitch_strobe got %0d required 0", strobes);
    end
    total++;
    if (bus.rx_data !== last_good) begin
      bad++;
      $display("FAIL glitch_data got %h required %h", bus.rx_data, last_good);
    end
  endtask

  task automatic test_frame_err();
    fork
      begin
        send_frame(8'h11, 1'b1);
        send_frame(8'h3C, 1'b0);
        bus.rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        send_frame(8'h5A, 1'b1);
      end
      collect(3, 800);
    join
    total++;
    if (bus.rx_data !== 8'h5A) begin
      bad++;
      $display("FAIL frame_err_recover got %h required 5a", bus.rx_data);
    end
    watch_quiet("frame_err_after", 40);
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    d = 8'hC3;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(d[i]);
    rst_n  = 1'b0;
    bus.rx = 1'b1;
    repeat (5) @(negedge clk);
    check_idle_outputs("mid_reset_hold");
    rst_n     = 1'b1;
    last_good = 8'h00;
    watch_quiet("mid_reset_quiet", 300);
    fork
      send_frame(8'h96, 1'b1);
      collect(1, 260);
    join
    total++;
    if (bus.rx_data !== 8'h96) begin
      bad++;
      $display("FAIL mid_reset_next got %h required 96", bus.rx_data);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_mid();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL leftover_expected got %0d required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
